// File: rtl/neo_clkrst_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : neo_clkrst_gen                                             |
// | Description : Reset sequencer and clock-enable generator on MCLK.        |
// |               Debounces the board reset button, stretches the system     |
// |               reset to a minimum width and produces NUM_CE phase-aligned |
// |               clock-enable pulses with runtime divisors.                 |
// | Optional    : define WATCHDOG_EN to add the watchdog (WD_KICK/WD_FIRED). |
// | Ports       : MCLK        system clock                                   |
// |               RESET       synchronous active-high reset                  |
// |               nRESET_BTN  raw board button, asynchronous, active-low     |
// |               DIV_CFG     channel i divisor at [i*DIV_WIDTH +: DIV_WIDTH]|
// |               CE_OUT      one-cycle clock-enable pulses                  |
// |               nRESET_OUT  active-low reset to the core                   |
// |               RST_BUSY    high while the sequencer is not in RUN         |
// |               WD_KICK     watchdog kick pulse      (WATCHDOG_EN only)    |
// |               WD_FIRED    sticky watchdog flag     (WATCHDOG_EN only)    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module neo_clkrst_gen #(
  parameter int NUM_CE          = 4,
  parameter int DIV_WIDTH       = 8,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int RST_HOLD_CYCLES = 16
`ifdef WATCHDOG_EN
  ,
  parameter int WD_CYCLES       = 65536
`endif
) (
  input  logic                        MCLK,
  input  logic                        RESET,
  input  logic                        nRESET_BTN,
  input  logic [NUM_CE*DIV_WIDTH-1:0] DIV_CFG,
  output logic [NUM_CE-1:0]           CE_OUT,
  output logic                        nRESET_OUT,
  output logic                        RST_BUSY
`ifdef WATCHDOG_EN
  ,
  input  logic                        WD_KICK,
  output logic                        WD_FIRED
`endif
);

  localparam int c_HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam int c_DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [c_DEB_W-1:0]  c_DEB_LAST  = c_DEB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] c_ST_ASSERT = 1'b0;
  localparam logic [0:0] c_ST_RUN    = 1'b1;

  logic [0:0]          r_state;
  logic                r_btn_meta;
  logic                r_btn_s;
  logic [c_HOLD_W-1:0] r_hold_cnt;
  logic [c_DEB_W-1:0]  r_deb_cnt;
  logic                r_nreset_out;
  logic                r_rst_busy;
  logic                w_deb_expire;
  logic                w_to_assert;

  // Only a full run of consecutive low samples ends in a reset request.
  assign w_deb_expire = (r_state == c_ST_RUN) && !r_btn_s && (r_deb_cnt == c_DEB_LAST);

`ifdef WATCHDOG_EN
  localparam int c_WD_W = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(WD_CYCLES - 1);

  logic [c_WD_W-1:0] r_wd_cnt;
  logic              r_wd_fired;
  logic              w_wd_expire;

  // A kick in the terminal cycle wins over expiry.
  assign w_wd_expire = (r_state == c_ST_RUN) && !WD_KICK && (r_wd_cnt == c_WD_LAST);
  // Debounce and watchdog collapse into one ASSERT entry.
  assign w_to_assert = w_deb_expire | w_wd_expire;

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      r_wd_cnt   <= '0;
      r_wd_fired <= 1'b0;
    end else if (r_state != c_ST_RUN) begin
      r_wd_cnt   <= '0;
    end else if (WD_KICK) begin
      r_wd_cnt   <= '0;
      r_wd_fired <= 1'b0;
    end else if (w_wd_expire) begin
      r_wd_cnt   <= '0;
      r_wd_fired <= 1'b1;
    end else begin
      r_wd_cnt   <= r_wd_cnt + 1'b1;
    end
  end

  assign WD_FIRED = r_wd_fired;
`else
  assign w_to_assert = w_deb_expire;
`endif

  // Sequencer: outputs are registered alongside the state so they change on
  // the same edge as the state transition.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      r_btn_meta   <= 1'b1;
      r_btn_s      <= 1'b1;
      r_state      <= c_ST_ASSERT;
      r_hold_cnt   <= '0;
      r_deb_cnt    <= '0;
      r_nreset_out <= 1'b0;
      r_rst_busy   <= 1'b1;
    end else begin
      r_btn_meta <= nRESET_BTN;
      r_btn_s    <= r_btn_meta;
      case (r_state)
        c_ST_ASSERT: begin
          r_deb_cnt <= '0;
          // A held button keeps the hold count at zero, extending the reset.
          if (!r_btn_s) begin
            r_hold_cnt <= '0;
          end else if (r_hold_cnt == c_HOLD_LAST) begin
            r_hold_cnt   <= '0;
            r_state      <= c_ST_RUN;
            r_nreset_out <= 1'b1;
            r_rst_busy   <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: begin
          r_hold_cnt <= '0;
          if (r_btn_s) begin
            r_deb_cnt <= '0;
          end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
          end
          if (w_to_assert) begin
            r_deb_cnt    <= '0;
            r_state      <= c_ST_ASSERT;
            r_nreset_out <= 1'b0;
            r_rst_busy   <= 1'b1;
          end
        end
      endcase
    end
  end

  assign nRESET_OUT = r_nreset_out;
  assign RST_BUSY   = r_rst_busy;

  // Clock-enable channels. Counters are cleared only by RESET, never by the
  // sequencer, so channels with related divisors keep a common phase.
  for (genvar gi = 0; gi < NUM_CE; gi++) begin : g_ce
    logic [DIV_WIDTH-1:0] w_div;
    logic [DIV_WIDTH-1:0] w_lim;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic                 r_ce;

    assign w_div = DIV_CFG[gi*DIV_WIDTH +: DIV_WIDTH];
    // A zero divisor behaves as one.
    assign w_lim = (w_div == '0) ? '0 : (w_div - 1'b1);

    // ">=" lets a lowered divisor wrap immediately instead of overrunning.
    always_ff @(posedge MCLK) begin
      if (RESET) begin
        r_cnt <= '0;
        r_ce  <= 1'b0;
      end else if (r_cnt >= w_lim) begin
        r_cnt <= '0;
        r_ce  <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
        r_ce  <= 1'b0;
      end
    end

    assign CE_OUT[gi] = r_ce;
  end

endmodule
`default_nettype wire

// File: tb/tb_neo_clkrst_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_neo_clkrst_gen                                          |
// | Description : Directed self-checking bench for neo_clkrst_gen.           |
// |               Watchdog scenario included when WATCHDOG_EN is defined.    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_neo_clkrst_gen;

  logic        MCLK       = 1'b0;
  logic        RESET      = 1'b1;
  logic        nRESET_BTN = 1'b1;
  logic [31:0] DIV_CFG    = 32'h0101_0101;
  logic [3:0]  CE_OUT;
  logic        nRESET_OUT;
  logic        RST_BUSY;
`ifdef WATCHDOG_EN
  logic        wd_auto    = 1'b1;
  logic        wd_man     = 1'b0;
  logic        WD_KICK;
  logic        WD_FIRED;
  assign WD_KICK = wd_auto | wd_man;
`endif

  int checks = 0;
  int errors = 0;

  always #5 MCLK = ~MCLK;

  neo_clkrst_gen #(
    .NUM_CE          (4),
    .DIV_WIDTH       (8),
    .DEBOUNCE_CYCLES (1024),
    .RST_HOLD_CYCLES (16)
`ifdef WATCHDOG_EN
    ,
    .WD_CYCLES       (100)
`endif
  ) dut (
    .MCLK       (MCLK),
    .RESET      (RESET),
    .nRESET_BTN (nRESET_BTN),
    .DIV_CFG    (DIV_CFG),
    .CE_OUT     (CE_OUT),
    .nRESET_OUT (nRESET_OUT),
    .RST_BUSY   (RST_BUSY)
`ifdef WATCHDOG_EN
    ,
    .WD_KICK    (WD_KICK),
    .WD_FIRED   (WD_FIRED)
`endif
  );

  // Advance n rising edges; inputs are driven and outputs sampled 1 ns later.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge MCLK);
      #1;
    end
  endtask

  // n edges with RESET high; returns just after the last reset edge.
  task automatic do_reset(input int n);
    RESET = 1'b1;
    step(n);
    RESET = 1'b0;
  endtask

  task automatic test_reset;
    int bad_low;
    DIV_CFG    = 32'h0101_0101;
    nRESET_BTN = 1'b1;
    do_reset(3);
    checks++;
    if (nRESET_OUT !== 1'b0 || RST_BUSY !== 1'b1 || CE_OUT !== 4'h0) begin
      errors++;
      $display("FAIL reset_state got nrst=%b busy=%b ce=%h want nrst=0 busy=1 ce=0",
               nRESET_OUT, RST_BUSY, CE_OUT);
    end
`ifdef WATCHDOG_EN
    checks++;
    if (WD_FIRED !== 1'b0) begin
      errors++;
      $display("FAIL reset_wd_fired got %b want 0", WD_FIRED);
    end
`endif
    bad_low = 0;
    for (int i = 0; i < 16; i++) begin
      if (nRESET_OUT !== 1'b0 || RST_BUSY !== 1'b1) bad_low++;
      step(1);
    end
    checks++;
    if (bad_low != 0) begin
      errors++;
      $display("FAIL reset_hold_low got %0d early-release cycles want 0", bad_low);
    end
    checks++;
    if (nRESET_OUT !== 1'b1 || RST_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got nrst=%b busy=%b want nrst=1 busy=0",
               nRESET_OUT, RST_BUSY);
    end
  endtask

  task automatic test_clock_enables;
    logic [3:0] exp_ce;
    int first_all;
    // ch0 div1, ch1 div2, ch2 div3, ch3 div4
    DIV_CFG = {8'd4, 8'd3, 8'd2, 8'd1};
    do_reset(1);
    first_all = 0;
    for (int k = 1; k <= 24; k++) begin
      step(1);
      for (int i = 0; i < 4; i++) exp_ce[i] = ((k % (i + 1)) == 0);
      checks++;
      if (CE_OUT !== exp_ce) begin
        errors++;
        $display("FAIL ce_pattern cycle %0d got %b want %b", k, CE_OUT, exp_ce);
      end
      if (first_all == 0 && CE_OUT === 4'hF) first_all = k;
    end
    checks++;
    if (first_all != 12) begin
      errors++;
      $display("FAIL ce_coincide got cycle %0d want 12", first_all);
    end
  endtask

  task automatic test_debounce;
    int highs;
    int lows;
    int lat;
    DIV_CFG    = 32'h0101_0101;
    nRESET_BTN = 1'b1;
    do_reset(1);
    step(20);
    checks++;
    if (nRESET_OUT !== 1'b1) begin
      errors++;
      $display("FAIL deb_in_run got %b want 1", nRESET_OUT);
    end
    // 500-cycle glitch must be rejected
    lows = 0;
    nRESET_BTN = 1'b0;
    for (int k = 0; k < 500; k++) begin
      step(1);
      if (nRESET_OUT !== 1'b1) lows++;
    end
    nRESET_BTN = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step(1);
      if (nRESET_OUT !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin
      errors++;
      $display("FAIL deb_glitch got %0d low cycles want 0", lows);
    end
    // Long press: 2 sync cycles + 1024 debounce cycles
    nRESET_BTN = 1'b0;
    lat = 0;
    for (int k = 1; k <= 1200; k++) begin
      step(1);
      if (nRESET_OUT === 1'b0) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != 1026 || RST_BUSY !== 1'b1) begin
      errors++;
      $display("FAIL deb_press_latency got %0d busy=%b want 1026 busy=1", lat, RST_BUSY);
    end
    highs = 0;
    for (int k = lat; k < 1100; k++) begin
      step(1);
      if (nRESET_OUT !== 1'b0) highs++;
    end
    checks++;
    if (highs != 0) begin
      errors++;
      $display("FAIL deb_held_low got %0d high cycles want 0", highs);
    end
    // Release: 2 sync cycles + 16 hold cycles
    nRESET_BTN = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (nRESET_OUT === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != 18 || RST_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL deb_release_latency got %0d busy=%b want 18 busy=0", lat, RST_BUSY);
    end
  endtask

  task automatic test_div_change;
    logic [3:0] exp_ce;
    int k;
    // ch0 div1, ch1 div3, ch2 div0 (acts as 1), ch3 div200
    DIV_CFG = {8'd200, 8'd0, 8'd3, 8'd1};
    do_reset(1);
    step(150);
    checks++;
    if (CE_OUT[3] !== 1'b0) begin
      errors++;
      $display("FAIL div_before_change got %b want 0", CE_OUT[3]);
    end
    DIV_CFG[31:24] = 8'd10;
    for (int j = 1; j <= 31; j++) begin
      step(1);
      k = 150 + j;
      exp_ce = {((j - 1) % 10) == 0, 1'b1, (k % 3) == 0, 1'b1};
      checks++;
      if (CE_OUT !== exp_ce) begin
        errors++;
        $display("FAIL div_change cycle %0d got %b want %b", j, CE_OUT, exp_ce);
      end
    end
  endtask

  task automatic test_reset_midop;
    int lat;
    int highs;
    DIV_CFG    = {8'd4, 8'd3, 8'd2, 8'd1};
    nRESET_BTN = 1'b1;
    // From RUN
    do_reset(1);
    step(20);
    do_reset(1);
    checks++;
    if (nRESET_OUT !== 1'b0 || RST_BUSY !== 1'b1 || CE_OUT !== 4'h0) begin
      errors++;
      $display("FAIL midop_reset got nrst=%b busy=%b ce=%h want 0 1 0",
               nRESET_OUT, RST_BUSY, CE_OUT);
    end
    // Hold count partially advanced, then RESET: full 16 again
    step(10);
    do_reset(1);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (nRESET_OUT === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != 16) begin
      errors++;
      $display("FAIL midop_hold_restart got %0d want 16", lat);
    end
    // RESET in ASSERT with button held low
    do_reset(1);
    nRESET_BTN = 1'b0;
    step(5);
    do_reset(1);
    highs = 0;
    for (int k = 0; k < 40; k++) begin
      step(1);
      if (nRESET_OUT !== 1'b0) highs++;
    end
    checks++;
    if (highs != 0) begin
      errors++;
      $display("FAIL midop_btn_low got %0d high cycles want 0", highs);
    end
    nRESET_BTN = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (nRESET_OUT === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != 18) begin
      errors++;
      $display("FAIL midop_btn_release got %0d want 18", lat);
    end
  endtask

`ifdef WATCHDOG_EN
  task automatic test_watchdog;
    int lat;
    int lows;
    nRESET_BTN = 1'b1;
    wd_auto    = 1'b0;
    wd_man     = 1'b0;
    do_reset(1);
    step(16);
    checks++;
    if (nRESET_OUT !== 1'b1) begin
      errors++;
      $display("FAIL wd_enter_run got %b want 1", nRESET_OUT);
    end
    lat = 0;
    for (int k = 1; k <= 150; k++) begin
      step(1);
      if (nRESET_OUT === 1'b0) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != 100 || WD_FIRED !== 1'b1) begin
      errors++;
      $display("FAIL wd_expire got %0d fired=%b want 100 fired=1", lat, WD_FIRED);
    end
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (nRESET_OUT === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != 16 || WD_FIRED !== 1'b1) begin
      errors++;
      $display("FAIL wd_hold got %0d fired=%b want 16 fired=1", lat, WD_FIRED);
    end
    wd_man = 1'b1;
    step(1);
    wd_man = 1'b0;
    checks++;
    if (WD_FIRED !== 1'b0) begin
      errors++;
      $display("FAIL wd_kick_clear got %b want 0", WD_FIRED);
    end
    lows = 0;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 49; k++) begin
        step(1);
        if (nRESET_OUT !== 1'b1) lows++;
      end
      wd_man = 1'b1;
      step(1);
      wd_man = 1'b0;
    end
    checks++;
    if (lows != 0 || WD_FIRED !== 1'b0) begin
      errors++;
      $display("FAIL wd_periodic_kick got %0d low cycles fired=%b want 0 0", lows, WD_FIRED);
    end
    wd_auto = 1'b1;
  endtask
`endif

  initial begin
    test_reset;
    test_clock_enables;
    test_debounce;
    test_div_change;
    test_reset_midop;
`ifdef WATCHDOG_EN
    test_watchdog;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
